dcache_2way_top: RTL and testbench
==================================

# dcache_2way_top

Two-way set-associative, write-back, write-allocate L1 data cache with true-LRU replacement per set. It is the parametrised successor of the direct-mapped data cache and sits between the CPU MEM stage (32-bit word port with stall) and the line-wide data memory (enable/ack handshake). Tag, state and data arrays are internal register arrays, so no external SRAM macros are needed.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- INDEX_W, 4, set index bits (2^INDEX_W sets × 2 ways; default capacity 32 lines)
- LINE_W, 256, line width in bits; power of two, ≥64; OFF_W = log2(LINE_W/8); TAG_W = ADDR_W-INDEX_W-OFF_W

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- p1_addr_i  in  ADDR_W  byte address; bits [1:0] ignored (word access only)
- p1_data_i  in  32  store data
- p1_MemRead_i  in  1  load request
- p1_MemWrite_i  in  1  store request (mutually exclusive with MemRead)
- p1_data_o  out  32  load data, valid while hit
- p1_stall_o  out  1  request pending, not yet serviced
- mem_addr_o  out  ADDR_W  line-aligned address (low OFF_W bits zero)
- mem_data_o  out  LINE_W  victim line for writeback
- mem_enable_o  out  1  memory request, held until ack
- mem_write_o  out  1  1 = writeback, 0 = refill
- mem_data_i  in  LINE_W  refill line
- mem_ack_i  in  1  one-cycle completion pulse
- hit_cnt_o  out  32  accesses that hit in IDLE (see Configuration)
- miss_cnt_o  out  32  misses detected in IDLE (see Configuration)

## Operation
- Per way, per set: valid, dirty, tag[TAG_W], data[LINE_W]. Per set: lru (1 = way1 is least recently used).
- Lookup is combinational, from the IDLE state only. A hit means valid && tag match in exactly one way. p1_stall_o = req && !(state==IDLE && hit).
- Load hit: p1_data_o = line word addr[OFF_W-1:2]. p1_data_o is 0 when there is no hit.
- Store hit: at the clock edge, write the 32-bit word into the line, set dirty.
- Any hit in IDLE: lru ← way not hit.
- Victim selection on a miss: the first invalid way (way0 preferred); otherwise the lru way. The victim is latched in the MISS state.
- FSM states and transitions:
  - IDLE: req && miss → MISS.
  - MISS: if the victim is valid && dirty → WRITEBACK, with mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 0}, mem_data_o=victim line. Otherwise → REFILL, with mem_enable_o=1, mem_write_o=0, mem_addr_o={req tag, index, 0}.
  - WRITEBACK: on ack → REFILL (enable stays 1, write→0, addr→request line). Without ack, hold all outputs.
  - REFILL: on ack, capture mem_data_i into the victim way, valid=1, dirty=0, tag=req tag, mem_enable_o→0, → FILL.
  - FILL: → IDLE. The request then re-looks-up, hits, and completes as a normal hit, updating dirty/lru.
- mem_ack_i is ignored outside WRITEBACK/REFILL.
- The CPU holds addr/data/request stable while stalled. Dropping the request mid-miss still completes the line fill.
- Reset, at any time including mid-transaction:
  - state=IDLE
  - all valid/dirty/lru cleared
  - mem_enable_o=0, mem_write_o=0, mem_addr_o=0
  - counters cleared
  - An outstanding memory transaction is abandoned; the memory model must tolerate this.

## Timing
- Hit: zero added latency; stall low in the same cycle; the store is committed at that edge.
- Clean miss with request at cycle T (IDLE): T+1 MISS; from T+2, REFILL with enable high; ack at cycle A; A+1 FILL; A+2 IDLE, stall low, access completes.
- Dirty miss: same sequence, with WRITEBACK preceding REFILL. mem_enable_o stays high continuously from the MISS exit until the refill ack.
- mem_enable_o, mem_write_o and mem_addr_o are registered. mem_data_o is taken from the latched victim line.

## Configuration
- DCACHE_STATS_EN defined:
  - hit_cnt_o increments on each cycle with state==IDLE && req && hit.
  - miss_cnt_o increments on each IDLE→MISS transition.
  - Both counters wrap at 2^32.
- DCACHE_STATS_EN undefined: no counter logic is built; both outputs are tied to 0.

## Test plan
- Reset → stall=0, mem_enable_o=0; load of 0x0000_0040 → miss, mem_addr_o=0x40, mem_write_o=0; ack with line word2=0xDEADBEEF → after FILL, load of 0x48 returns 0xDEADBEEF, stall low.
- Store 0x12345678 to 0x40 (hit) → load of 0x40 returns 0x12345678 on the next cycle, no memory traffic.
- Same set, three tags: load 0x040, 0x240, 0x440 (INDEX_W=4) → third miss evicts the 0x040 line; dirty from the prior store → WRITEBACK at 0x040 with the stored word, then REFILL at 0x440.
- LRU: access 0x040, 0x240, 0x040, then 0x440 → victim is the way holding 0x240; no writeback (clean).
- Assert rst_i during REFILL before ack → mem_enable_o=0 asynchronously; after release, a load of 0x040 misses.
- With DCACHE_STATS_EN: the above sequence yields the expected hit/miss counts; without the macro, both counters read 0.

Source files
------------

// File: rtl/dcache_2way_top.sv
// dcache_2way_top: two-way set-associative, write-back, write-allocate L1 data cache with true LRU.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
module dcache_2way_top #(
    parameter int ADDR_W  = 32,
    parameter int INDEX_W = 4,
    parameter int LINE_W  = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int TAG_W  = ADDR_W - INDEX_W - OFF_W;
    localparam int SETS   = 1 << INDEX_W;
    localparam int WSEL_W = OFF_W - 2;

    typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, REFILL, FILL} state_t;

    state_t             state;
    logic               valid_q [2][SETS];
    logic               dirty_q [2][SETS];
    logic [TAG_W-1:0]   tag_q   [2][SETS];
    logic [LINE_W-1:0]  data_q  [2][SETS];
    logic [SETS-1:0]    lru_q;
    logic               victim;
    logic [INDEX_W-1:0] miss_idx;
    logic [TAG_W-1:0]   miss_tag;

    logic               req, hit0, hit1, hit, hit_way, lookup_hit, victim_sel;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_idx;
    logic [WSEL_W-1:0]  req_word;
    logic [OFF_W+2:0]   word_bit;
    logic [LINE_W-1:0]  hit_line;
    logic [1:0]         unused_byte_sel;

    assign req             = p1_MemRead_i | p1_MemWrite_i;
    assign req_tag         = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign req_idx         = p1_addr_i[OFF_W +: INDEX_W];
    assign req_word        = p1_addr_i[2 +: WSEL_W];
    assign word_bit        = {req_word, 5'b0};
    assign unused_byte_sel = p1_addr_i[1:0];

    assign hit0       = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
    assign hit1       = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
    assign hit        = hit0 ^ hit1;
    assign hit_way    = hit1;
    assign lookup_hit = (state == IDLE) && hit;
    assign hit_line   = data_q[hit_way][req_idx];
    assign p1_stall_o = req && !lookup_hit;
    assign p1_data_o  = lookup_hit ? hit_line[word_bit +: 32] : 32'd0;

    // Fill an invalid way first (way0 preferred), otherwise evict the LRU way.
    assign victim_sel = !valid_q[0][req_idx] ? 1'b0 :
                        !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            lru_q        <= '0;
            victim       <= 1'b0;
            miss_idx     <= '0;
            miss_tag     <= '0;
            for (int w = 0; w < 2; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req && hit) begin
                        lru_q[req_idx] <= ~hit_way;
                        if (p1_MemWrite_i) dirty_q[hit_way][req_idx] <= 1'b1;
                    end else if (req) begin
                        state    <= MISS;
                        victim   <= victim_sel;
                        miss_idx <= req_idx;
                        miss_tag <= req_tag;
                    end
                end
                MISS: begin
                    mem_enable_o <= 1'b1;
                    if (valid_q[victim][miss_idx] && dirty_q[victim][miss_idx]) begin
                        state       <= WRITEBACK;
                        mem_write_o <= 1'b1;
                        mem_addr_o  <= {tag_q[victim][miss_idx], miss_idx, {OFF_W{1'b0}}};
                    end else begin
                        state       <= REFILL;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= {miss_tag, miss_idx, {OFF_W{1'b0}}};
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        state       <= REFILL;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= {miss_tag, miss_idx, {OFF_W{1'b0}}};
                    end
                end
                REFILL: begin
                    if (mem_ack_i) begin
                        state                     <= FILL;
                        mem_enable_o              <= 1'b0;
                        valid_q[victim][miss_idx] <= 1'b1;
                        dirty_q[victim][miss_idx] <= 1'b0;
                    end
                end
                FILL:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: tag/data storage and the victim-line buffer are not reset; valid bits gate every use.
    always_ff @(posedge clk_i) begin
        if (lookup_hit && p1_MemWrite_i)
            data_q[hit_way][req_idx][word_bit +: 32] <= p1_data_i;
        if (state == MISS)
            mem_data_o <= data_q[victim][miss_idx];
        if (state == REFILL && mem_ack_i) begin
            data_q[victim][miss_idx] <= mem_data_i;
            tag_q[victim][miss_idx]  <= miss_tag;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (req && lookup_hit) hit_cnt <= hit_cnt + 32'd1;
            if (req && state == IDLE && !hit) miss_cnt <= miss_cnt + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt;
    assign miss_cnt_o = miss_cnt;
`else
    assign hit_cnt_o  = 32'd0;
    assign miss_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_2way_top.sv
// Self-checking bench for dcache_2way_top: directed scenarios plus random traffic against a
// set/recency-list reference model and a line-granular backing memory.
module tb_dcache_2way_top;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic [31:0]  p1_addr_i = '0;
    logic [31:0]  p1_data_i = '0;
    logic         p1_MemRead_i = 1'b0;
    logic         p1_MemWrite_i = 1'b0;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;

    dcache_2way_top dut (
        .clk_i(clk), .rst_i(rst_i),
        .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
        .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
        .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } txn_t;

    int               n_checks = 0;
    int               n_fail   = 0;
    txn_t             log_q[$];
    txn_t             last_log[$];
    bit               last_hit;
    bit               hold_ack = 1'b0;
    int unsigned      exp_hits = 0;
    int unsigned      exp_miss = 0;

    // Reference state: backing memory by line number, CPU-visible word overlay, per-set recency lists.
    logic [255:0]     memline [int unsigned];
    logic [31:0]      gold    [logic [31:0]];
    bit               dirty_m [int unsigned];
    int unsigned      set_q   [16][$];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] default_word(input logic [31:0] a);
        return ((a & ~32'd3) * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [255:0] mem_line(input int unsigned line);
        logic [255:0] l = '0;
        if (memline.exists(line)) return memline[line];
        for (int w = 7; w >= 0; w--) l = {l[223:0], default_word((line << 5) + w * 4)};
        return l;
    endfunction

    function automatic logic [31:0] gold_word(input logic [31:0] a);
        logic [255:0] l;
        logic [31:0]  wa = a & ~32'd3;
        if (gold.exists(wa)) return gold[wa];
        l = mem_line(wa >> 5) >> (((wa >> 2) & 32'd7) * 32);
        return l[31:0];
    endfunction

    function automatic logic [255:0] gold_line(input int unsigned line);
        logic [255:0] l = '0;
        for (int w = 7; w >= 0; w--) l = {l[223:0], gold_word((line << 5) + w * 4)};
        return l;
    endfunction

    task automatic model_reset();
        gold.delete();
        dirty_m.delete();
        for (int s = 0; s < 16; s++) set_q[s].delete();
        exp_hits = 0;
        exp_miss = 0;
    endtask

    // Backing memory: acknowledges after a random delay unless hold_ack is set.
    initial begin : mem_model
        bit busy = 1'b0;
        int dly  = 0;
        forever begin
            @(negedge clk);
            mem_ack_i = 1'b0;
            if (rst_i) begin
                busy = 1'b0;
            end else if (mem_enable_o) begin
                if (!busy) begin
                    busy = 1'b1;
                    dly  = $urandom_range(0, 3);
                    log_q.push_back('{mem_write_o, mem_addr_o, mem_data_o});
                end
                if (!hold_ack) begin
                    if (dly == 0) begin
                        if (mem_write_o) memline[mem_addr_o >> 5] = mem_data_o;
                        else mem_data_i = mem_line(mem_addr_o >> 5);
                        mem_ack_i = 1'b1;
                        busy      = 1'b0;
                    end else begin
                        dly--;
                    end
                end
            end
        end
    end

    task automatic access(input logic [31:0] addr, input bit we, input logic [31:0] wdata);
        int unsigned line = addr >> 5;
        int unsigned set  = line % 16;
        int          pos  = -1;
        int          n_exp;
        bit          pred_hit, pred_wb = 1'b0;
        int unsigned vic = 0;
        logic [255:0] wb_data = '0;

        for (int i = 0; i < set_q[set].size(); i++) if (set_q[set][i] == line) pos = i;
        pred_hit = (pos >= 0);
        if (pred_hit) begin
            set_q[set].delete(pos);
        end else begin
            exp_miss++;
            if (set_q[set].size() == 2) begin
                vic = set_q[set].pop_back();
                if (dirty_m.exists(vic)) begin
                    pred_wb = 1'b1;
                    wb_data = gold_line(vic);
                    dirty_m.delete(vic);
                end
            end
        end
        set_q[set].push_front(line);
        n_exp = pred_hit ? 0 : (pred_wb ? 2 : 1);

        @(negedge clk);
        log_q.delete();
        p1_addr_i     = addr;
        p1_data_i     = wdata;
        p1_MemRead_i  = !we;
        p1_MemWrite_i = we;
        #1;
        last_hit = !p1_stall_o;
        check("hit_vs_model", last_hit, pred_hit);
        for (int c = 0; c < 200 && p1_stall_o; c++) begin
            @(negedge clk);
            #1;
        end
        if (p1_stall_o) begin
            check("stall_timeout", 1, 0);
        end else begin
            if (!we) check("load_data", p1_data_o, gold_word(addr));
            check("enable_low_at_done", mem_enable_o, 0);
            exp_hits++;
        end
        last_log = log_q;
        check("txn_count", log_q.size(), n_exp);
        if (!pred_hit && log_q.size() == n_exp) begin
            if (pred_wb) begin
                check("wb_write_flag", log_q[0].wr, 1);
                check("wb_addr", log_q[0].addr, vic << 5);
                check("wb_data", log_q[0].data, wb_data);
            end
            check("refill_write_flag", log_q[n_exp-1].wr, 0);
            check("refill_addr", log_q[n_exp-1].addr, line << 5);
        end
        if (we) begin
            gold[addr & ~32'd3] = wdata;
            dirty_m[line]       = 1'b1;
        end
        @(posedge clk);
        #1;
        p1_MemRead_i  = 1'b0;
        p1_MemWrite_i = 1'b0;
    endtask

    task automatic check_counters(input string tag);
`ifdef DCACHE_STATS_EN
        check({tag, "_hit_cnt"}, hit_cnt_o, exp_hits);
        check({tag, "_miss_cnt"}, miss_cnt_o, exp_miss);
`else
        check({tag, "_hit_cnt"}, hit_cnt_o, 0);
        check({tag, "_miss_cnt"}, miss_cnt_o, 0);
`endif
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [255:0] seed_line;
        seed_line = mem_line(2);
        seed_line[95:64] = 32'hDEAD_BEEF;
        memline[2] = seed_line;

        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        check("reset_stall", p1_stall_o, 0);
        check("reset_enable", mem_enable_o, 0);
        check("reset_write", mem_write_o, 0);
        check("reset_addr", mem_addr_o, 0);
        check("reset_rdata", p1_data_o, 0);
        check_counters("reset");

        access(32'h40, 0, 0);
        check("first_miss", last_hit, 0);
        access(32'h48, 0, 0);
        check("fill_hit", last_hit, 1);
        check("fill_word2", p1_data_o, 32'hDEAD_BEEF);
        access(32'h40, 1, 32'h1234_5678);
        check("store_hit", last_hit, 1);
        access(32'h40, 0, 0);
        check("store_readback", p1_data_o, 32'h1234_5678);
        check("readback_no_traffic", last_log.size(), 0);

        access(32'h240, 0, 0);
        access(32'h440, 0, 0);
        check("evict_txns", last_log.size(), 2);
        if (last_log.size() == 2) begin
            check("evict_wb_addr", last_log[0].addr, 32'h40);
            check("evict_wb_word0", last_log[0].data[31:0], 32'h1234_5678);
            check("evict_refill_addr", last_log[1].addr, 32'h440);
        end
        check_counters("directed");

        // Abandon a refill with reset before the memory acknowledges.
        @(negedge clk);
        hold_ack = 1'b1;
        p1_addr_i = 32'h640;
        p1_MemRead_i = 1'b1;
        for (int c = 0; c < 50 && !(mem_enable_o && !mem_write_o); c++) @(negedge clk);
        check("reached_refill", mem_enable_o && !mem_write_o, 1);
        check("refill_640_addr", mem_addr_o, 32'h640);
        #2 rst_i = 1'b1;
        #1;
        check("rst_async_enable", mem_enable_o, 0);
        check("rst_async_write", mem_write_o, 0);
        check("rst_async_addr", mem_addr_o, 0);
        @(negedge clk);
        p1_MemRead_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        hold_ack = 1'b0;
        model_reset();
        check_counters("post_reset");

        access(32'h40, 0, 0);
        check("post_reset_miss", last_hit, 0);
        check("post_reset_data", p1_data_o, 32'h1234_5678);
        access(32'h240, 0, 0);
        access(32'h40, 0, 0);
        access(32'h440, 0, 0);
        check("lru_clean_txns", last_log.size(), 1);
        if (last_log.size() == 1) check("lru_refill_addr", last_log[0].addr, 32'h440);
        access(32'h40, 0, 0);
        check("lru_kept_mru", last_hit, 1);
        access(32'h240, 0, 0);
        check("lru_evicted", last_hit, 0);
        check_counters("lru");

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 5) |
                ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            access(a, $urandom_range(0, 2) == 0, $urandom);
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        check_counters("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
